// File: rtl/cmp_window_monitor_pkg.sv
// rtl/cmp_window_monitor_pkg.sv - shared encodings for the compare window monitor
// Purpose: persistence FSM state encoding, event codes, sample classes and the
//          sample classifier used by the top module.
// Ports:   none (package)
package cmp_window_monitor_pkg;

  typedef enum logic [2:0] {
    ST_IN      = 3'd0,
    ST_HI_PEND = 3'd1,
    ST_HI      = 3'd2,
    ST_LO_PEND = 3'd3,
    ST_LO      = 3'd4
  } state_t;

  localparam logic [1:0] EVT_ENTER_HIGH = 2'b01;
  localparam logic [1:0] EVT_ENTER_LOW  = 2'b10;
  localparam logic [1:0] EVT_RETURN_IN  = 2'b11;

  typedef enum logic [1:0] {
    CLS_INWIN = 2'd0,
    CLS_ABOVE = 2'd1,
    CLS_BELOW = 2'd2
  } cls_t;

  // Classes a sample from its compare results against hi_thr and lo_thr.
  // Equality with either threshold counts as inside the window.
  function automatic cls_t classify(input logic gt_hi, input logic eq_hi, input logic lt_hi,
                                    input logic gt_lo, input logic eq_lo, input logic lt_lo);
    if (gt_hi) return CLS_ABOVE;
    if (lt_lo) return CLS_BELOW;
    if ((eq_hi | lt_hi) & (eq_lo | gt_lo)) return CLS_INWIN;
    // Compare outputs are one-hot, so this fallback is never taken.
    return CLS_INWIN;
  endfunction

endpackage

// File: rtl/cmp_window_monitor_if.sv
// rtl/cmp_window_monitor_if.sv - sample/event stream bundle for the window monitor
// Purpose: groups the sample input stream, thresholds, event output slot and
//          alarm levels of cmp_window_monitor.
// Ports:   master drives in_valid/sample/lo_thr/hi_thr/evt_ready;
//          slave drives in_ready/evt_valid/evt_code/alarm_hi/alarm_lo/cfg_err.
interface cmp_window_monitor_if #(
  parameter int W = 4
);
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] sample;
  logic [W-1:0] lo_thr;
  logic [W-1:0] hi_thr;
  logic         evt_valid;
  logic         evt_ready;
  logic [1:0]   evt_code;
  logic         alarm_hi;
  logic         alarm_lo;
  logic         cfg_err;

  modport master (
    output in_valid, sample, lo_thr, hi_thr, evt_ready,
    input  in_ready, evt_valid, evt_code, alarm_hi, alarm_lo, cfg_err
  );

  modport slave (
    input  in_valid, sample, lo_thr, hi_thr, evt_ready,
    output in_ready, evt_valid, evt_code, alarm_hi, alarm_lo, cfg_err
  );
endinterface

// File: rtl/cmp_window_monitor_mag_cmp.sv
// rtl/cmp_window_monitor_mag_cmp.sv - W-bit unsigned magnitude comparator
// Purpose: one-hot eq/gt/lt result of comparing a_i against b_i.
// Ports:   a_i, b_i (W-bit unsigned in); eq_o, gt_o, lt_o (1-bit out).
module mag_cmp_w #(
  parameter int W = 4
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  output logic         eq_o,
  output logic         gt_o,
  output logic         lt_o
);
  assign eq_o = (a_i == b_i);
  assign gt_o = (a_i >  b_i);
  assign lt_o = (a_i <  b_i);
endmodule

// File: rtl/cmp_window_monitor.sv
// rtl/cmp_window_monitor.sv - threshold window monitor with persistence filter
// Purpose: classifies accepted samples against lo/hi thresholds, filters them
//          through a persistence FSM into alarm levels and emits transition
//          events through a one-entry output slot.
// Ports:   clk (rising edge), rst (async active-high),
//          bus (slave modport: sample stream in, event slot and alarms out).
module cmp_window_monitor
  import cmp_window_monitor_pkg::*;
#(
  parameter int W       = 4,
  parameter int PERSIST = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  cmp_window_monitor_if.slave  bus
);
  localparam int          CW        = $clog2(PERSIST + 1);
  localparam logic [CW:0] PERSIST_C = (CW + 1)'(PERSIST);
  localparam bit          ONE_SHOT  = (PERSIST == 1);

  logic eq_hi, gt_hi, lt_hi;
  logic eq_lo, gt_lo, lt_lo;
  logic eq_lh, gt_lh, lt_lh;

  mag_cmp_w #(.W(W)) u_cmp_hi (.a_i(bus.sample), .b_i(bus.hi_thr), .eq_o(eq_hi), .gt_o(gt_hi), .lt_o(lt_hi));
  mag_cmp_w #(.W(W)) u_cmp_lo (.a_i(bus.sample), .b_i(bus.lo_thr), .eq_o(eq_lo), .gt_o(gt_lo), .lt_o(lt_lo));
  mag_cmp_w #(.W(W)) u_cmp_lh (.a_i(bus.lo_thr), .b_i(bus.hi_thr), .eq_o(eq_lh), .gt_o(gt_lh), .lt_o(lt_lh));

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          evt_valid_q, evt_valid_d;
  logic [1:0]    evt_code_q, evt_code_d;
  logic          alarm_hi_q, alarm_hi_d;
  logic          alarm_lo_q, alarm_lo_d;
  logic          cfg_err_q, cfg_err_d;

  logic          accept;
  logic          emit;
  logic [1:0]    emit_code;
  logic [CW:0]   cnt_inc;
  logic          reach;
  cls_t          cls;

  // The slot can take a new event whenever it is empty or draining this cycle,
  // so an accepted sample never overwrites an undelivered event.
  assign bus.in_ready = ~evt_valid_q | bus.evt_ready;
  assign accept       = bus.in_valid & bus.in_ready;
  assign cls          = classify(gt_hi, eq_hi, lt_hi, gt_lo, eq_lo, lt_lo);
  assign cnt_inc      = {1'b0, cnt_q} + (CW + 1)'(1);
  assign reach        = (cnt_inc >= PERSIST_C);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    cfg_err_d = cfg_err_q;
    emit      = 1'b0;
    emit_code = evt_code_q;

    if (accept) begin
      if (gt_lh) begin
        // Inverted thresholds: swallow the sample and drop any alarm silently.
        cfg_err_d = 1'b1;
        state_d   = ST_IN;
        cnt_d     = '0;
      end else if (eq_lh | lt_lh) begin
        cfg_err_d = 1'b0;
        case (state_q)
          ST_IN: begin
            if (cls == CLS_ABOVE) begin
              if (ONE_SHOT) begin
                state_d = ST_HI; cnt_d = '0; emit = 1'b1; emit_code = EVT_ENTER_HIGH;
              end else begin
                state_d = ST_HI_PEND; cnt_d = CW'(1);
              end
            end else if (cls == CLS_BELOW) begin
              if (ONE_SHOT) begin
                state_d = ST_LO; cnt_d = '0; emit = 1'b1; emit_code = EVT_ENTER_LOW;
              end else begin
                state_d = ST_LO_PEND; cnt_d = CW'(1);
              end
            end
          end
          ST_HI_PEND: begin
            if (cls == CLS_ABOVE) begin
              if (reach) begin
                state_d = ST_HI; cnt_d = '0; emit = 1'b1; emit_code = EVT_ENTER_HIGH;
              end else begin
                cnt_d = cnt_inc[CW-1:0];
              end
            end else if (cls == CLS_BELOW) begin
              state_d = ST_LO_PEND; cnt_d = CW'(1);
            end else begin
              state_d = ST_IN; cnt_d = '0;
            end
          end
          ST_LO_PEND: begin
            if (cls == CLS_BELOW) begin
              if (reach) begin
                state_d = ST_LO; cnt_d = '0; emit = 1'b1; emit_code = EVT_ENTER_LOW;
              end else begin
                cnt_d = cnt_inc[CW-1:0];
              end
            end else if (cls == CLS_ABOVE) begin
              state_d = ST_HI_PEND; cnt_d = CW'(1);
            end else begin
              state_d = ST_IN; cnt_d = '0;
            end
          end
          ST_HI: begin
            if (cls == CLS_ABOVE) begin
              cnt_d = '0;
            end else if (reach) begin
              state_d = ST_IN; cnt_d = '0; emit = 1'b1; emit_code = EVT_RETURN_IN;
            end else begin
              cnt_d = cnt_inc[CW-1:0];
            end
          end
          ST_LO: begin
            if (cls == CLS_BELOW) begin
              cnt_d = '0;
            end else if (reach) begin
              state_d = ST_IN; cnt_d = '0; emit = 1'b1; emit_code = EVT_RETURN_IN;
            end else begin
              cnt_d = cnt_inc[CW-1:0];
            end
          end
          default: begin
            state_d = ST_IN; cnt_d = '0;
          end
        endcase
      end
    end

    // A drain and a reload in the same cycle keep evt_valid high.
    evt_valid_d = (evt_valid_q & ~bus.evt_ready) | emit;
    evt_code_d  = emit ? emit_code : evt_code_q;
    alarm_hi_d  = (state_d == ST_HI);
    alarm_lo_d  = (state_d == ST_LO);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IN;
      cnt_q       <= '0;
      evt_valid_q <= 1'b0;
      evt_code_q  <= 2'b00;
      alarm_hi_q  <= 1'b0;
      alarm_lo_q  <= 1'b0;
      cfg_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      evt_valid_q <= evt_valid_d;
      evt_code_q  <= evt_code_d;
      alarm_hi_q  <= alarm_hi_d;
      alarm_lo_q  <= alarm_lo_d;
      cfg_err_q   <= cfg_err_d;
    end
  end

  assign bus.evt_valid = evt_valid_q;
  assign bus.evt_code  = evt_code_q;
  assign bus.alarm_hi  = alarm_hi_q;
  assign bus.alarm_lo  = alarm_lo_q;
  assign bus.cfg_err   = cfg_err_q;

endmodule

// File: tb/tb_cmp_window_monitor.sv
// tb/tb_cmp_window_monitor.sv - self-checking bench for cmp_window_monitor
module tb_cmp_window_monitor;
  localparam int W = 4;
  localparam int P = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cmp_window_monitor_if #(.W(W)) bus ();

  cmp_window_monitor #(.W(W), .PERSIST(P)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  // Reference model: alarm level (0 none, 1 high, 2 low) plus the classes of
  // every sample seen since the last level change (0 INWIN, 1 ABOVE, 2 BELOW).
  int         m_level;
  int         m_hist[$];
  bit         m_ev;
  logic [1:0] m_code;
  bit         m_cfg;

  // True when the last P recorded classes all equal want (negate=0) or all differ from it (negate=1).
  function automatic bit last_all(input int want, input bit negate);
    if (m_hist.size() < P) return 1'b0;
    for (int i = m_hist.size() - P; i < m_hist.size(); i++)
      if ((m_hist[i] == want) == negate) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_reset();
    m_level = 0;
    m_hist.delete();
    m_ev    = 1'b0;
    m_code  = 2'b00;
    m_cfg   = 1'b0;
  endtask

  task automatic check_outputs();
    chk("evt_valid", bus.evt_valid, m_ev);
    chk("evt_code",  bus.evt_code,  m_code);
    chk("alarm_hi",  bus.alarm_hi,  m_level == 1);
    chk("alarm_lo",  bus.alarm_lo,  m_level == 2);
    chk("cfg_err",   bus.cfg_err,   m_cfg);
  endtask

  // One clock: check registered outputs, drive inputs, check in_ready, advance model.
  task automatic step(input bit v, input logic [W-1:0] s, input logic [W-1:0] lo,
                      input logic [W-1:0] hi, input bit er);
    bit         rdy;
    bit         new_ev;
    logic [1:0] code;
    int         cls;
    @(negedge clk);
    check_outputs();
    bus.in_valid  = v;
    bus.sample    = s;
    bus.lo_thr    = lo;
    bus.hi_thr    = hi;
    bus.evt_ready = er;
    #1;
    rdy = !m_ev || er;
    chk("in_ready", bus.in_ready, rdy);
    new_ev = 1'b0;
    code   = m_code;
    if (v && rdy) begin
      if (lo > hi) begin
        m_cfg   = 1'b1;
        m_level = 0;
        m_hist.delete();
      end else begin
        m_cfg = 1'b0;
        cls = (s > hi) ? 1 : (s < lo) ? 2 : 0;
        m_hist.push_back(cls);
        if (m_level == 0) begin
          if (last_all(1, 1'b0)) begin m_level = 1; new_ev = 1'b1; code = 2'b01; end
          else if (last_all(2, 1'b0)) begin m_level = 2; new_ev = 1'b1; code = 2'b10; end
        end else if (m_level == 1) begin
          if (last_all(1, 1'b1)) begin m_level = 0; new_ev = 1'b1; code = 2'b11; end
        end else begin
          if (last_all(2, 1'b1)) begin m_level = 0; new_ev = 1'b1; code = 2'b11; end
        end
        if (new_ev) m_hist.delete();
        while (m_hist.size() > P) void'(m_hist.pop_front());
      end
    end
    m_ev = (m_ev && !er) || new_ev;
    if (new_ev) m_code = code;
  endtask

  task automatic send(input logic [W-1:0] s);
    step(1'b1, s, 4'd4, 4'd11, 1'b1);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 4'd0, 4'd4, 4'd11, 1'b1);
  endtask

  task automatic reset_mid();
    @(negedge clk);
    bus.in_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("rst_evt_valid", bus.evt_valid, 0);
    chk("rst_evt_code",  bus.evt_code,  0);
    chk("rst_alarm_hi",  bus.alarm_hi,  0);
    chk("rst_alarm_lo",  bus.alarm_lo,  0);
    chk("rst_cfg_err",   bus.cfg_err,   0);
    chk("rst_in_ready",  bus.in_ready,  1);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  logic [W-1:0] pick_tab [8];

  initial begin
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.sample    = '0;
    bus.lo_thr    = 4'd4;
    bus.hi_thr    = 4'd11;
    bus.evt_ready = 1'b1;
    model_reset();
    pick_tab = '{4'd3, 4'd4, 4'd5, 4'd10, 4'd11, 4'd12, 4'd13, 4'd0};
    reset_mid();

    // Reset mid-stream clears a partial count.
    send(12); send(12);
    reset_mid();
    send(12); send(12); idle(2);
    // Entering high, event visible for exactly one cycle.
    send(12); idle(3);
    // Leaving high back into the window.
    reset_mid();
    send(12); send(12); send(11); send(12); send(12); idle(1);
    send(4); send(4); send(3); send(3); send(3); idle(2);
    reset_mid();
    send(12); send(12); send(12);
    send(5); send(6); send(13); send(5); send(6); send(7); idle(2);
    // Backpressure on a pending event stalls the next sample.
    send(12); send(12); step(1'b1, 4'd12, 4'd4, 4'd11, 1'b0);
    step(1'b1, 4'd12, 4'd4, 4'd11, 1'b0);
    step(1'b1, 4'd12, 4'd4, 4'd11, 1'b0);
    step(1'b1, 4'd12, 4'd4, 4'd11, 1'b1);
    idle(2);
    // Inverted thresholds.
    for (int i = 0; i < 3; i++) step(1'b1, 4'd15, 4'd9, 4'd3, 1'b1);
    idle(1);
    send(7); idle(2);

    for (int n = 0; n < 3000; n++) begin
      logic [W-1:0] s, lo, hi;
      bit v, er;
      v  = ($urandom_range(0, 9) < 8);
      er = ($urandom_range(0, 3) != 0);
      s  = ($urandom_range(0, 7) == 0) ? W'($urandom) : pick_tab[$urandom_range(0, 6)];
      lo = 4'd4;
      hi = 4'd11;
      if ($urandom_range(0, 19) == 0) begin
        lo = W'($urandom);
        hi = W'($urandom);
      end
      if ($urandom_range(0, 299) == 0) reset_mid();
      else step(v, s, lo, hi, er);
    end
    idle(3);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
